// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared state encodings, opcodes, ALUOp codes, mux selects and control word for the multicycle MIPS controller
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL_WB    = 4'd12,
        S_TRAP      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALUOP_RTYPE = 3'b111;
    localparam logic [2:0] ALUOP_ADD   = 3'b100;
    localparam logic [2:0] ALUOP_OR    = 3'b101;
    localparam logic [2:0] ALUOP_LUI   = 3'b110;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MDR = 2'b01;
    localparam logic [1:0] MEMTOREG_PC  = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    function automatic logic [2:0] i_aluop(input logic [5:0] op);
        return (op == OP_ORI) ? ALUOP_OR : (op == OP_LUI) ? ALUOP_LUI : ALUOP_ADD;
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// control_decode: combinational Moore decode of state (+ latched opcode, Zero, MemReady) into the datapath control word
// Ports: state - current FSM state; op - latched opcode; zero - ALU zero flag;
//        mem_ready - memory completes access this cycle; ctrl - full control word
// Option: MULTICYCLE_JAL_EN adds the JAL_WB state decode.
module control_decode
    import multicycle_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  state_t              state,
    input  logic [OPCODE_W-1:0] op,
    input  logic                zero,
    input  logic                mem_ready,
    output ctrl_t               ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC only load on the cycle the instruction word arrives
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = MEMTOREG_MDR;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RD;
                ctrl.mem_to_reg = MEMTOREG_ALU;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = i_aluop(op);
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RT;
                ctrl.mem_to_reg = MEMTOREG_ALU;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_write  = (op == OP_BEQ) ? zero : ~zero;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MULTICYCLE_JAL_EN
            S_JAL_WB: begin
                // PC already holds PC+4 from fetch, so it is the link value
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REGDST_RA;
                ctrl.mem_to_reg = MEMTOREG_PC;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
            end
`endif
            S_TRAP: ctrl.illegal = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM sequencing fetch/decode/execute/memory/write-back for the multicycle MIPS datapath
// Ports: clk, reset (async active-low); Opcode (IR[31:26]), Zero, MemReady in;
//        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//        ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal, State (debug) out.
// Option: define MULTICYCLE_JAL_EN to support JAL via the JAL_WB state; otherwise JAL traps.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Zero,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic [1:0]          RegDst,
    output logic [1:0]          MemtoReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          ALUOp,
    output logic [1:0]          PCSource,
    output logic                Illegal,
    output logic [STATE_W-1:0]  State
);

    state_t              state, next_state;
    logic [OPCODE_W-1:0] op_q;
    ctrl_t               ctrl, ctrl_g;

    function automatic state_t dispatch(input logic [OPCODE_W-1:0] o);
        case (o)
            OP_RTYPE:                return S_R_EXEC;
            OP_ADDI, OP_ORI, OP_LUI: return S_I_EXEC;
            OP_LW, OP_SW:            return S_MEM_ADDR;
            OP_BEQ, OP_BNE:          return S_BRANCH;
            OP_J:                    return S_JUMP;
`ifdef MULTICYCLE_JAL_EN
            OP_JAL:                  return S_JAL_WB;
`endif
            default:                 return S_TRAP;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            op_q  <= '0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) op_q <= Opcode;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:     next_state = MemReady ? S_DECODE : S_FETCH;
            S_DECODE:    next_state = dispatch(Opcode);
            S_MEM_ADDR:  next_state = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  next_state = MemReady ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: next_state = MemReady ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    next_state = S_R_WB;
            S_I_EXEC:    next_state = S_I_WB;
            S_TRAP:      next_state = S_TRAP;
            default:     next_state = S_FETCH;
        endcase
    end

    control_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .state     (state),
        .op        (op_q),
        .zero      (Zero),
        .mem_ready (MemReady),
        .ctrl      (ctrl)
    );

    // Outputs are combinational, so gate them directly with reset to kill any write the instant reset falls
    assign ctrl_g   = reset ? ctrl : '0;
    assign PCWrite  = ctrl_g.pc_write;
    assign IorD     = ctrl_g.iord;
    assign MemRead  = ctrl_g.mem_read;
    assign MemWrite = ctrl_g.mem_write;
    assign IRWrite  = ctrl_g.ir_write;
    assign RegDst   = ctrl_g.reg_dst;
    assign MemtoReg = ctrl_g.mem_to_reg;
    assign RegWrite = ctrl_g.reg_write;
    assign ALUSrcA  = ctrl_g.alu_src_a;
    assign ALUSrcB  = ctrl_g.alu_src_b;
    assign ALUOp    = ctrl_g.alu_op;
    assign PCSource = ctrl_g.pc_source;
    assign Illegal  = ctrl_g.illegal;
    assign State    = STATE_W'(state);

endmodule
